// File: rtl/adc_emulador_spi.sv
// SPI ADC emulator: serves one PmodAD1-style frame per chip-select on NUM_CH
// parallel MISO lines. SCK/CS_N are asynchronous and are synchronized to clk;
// samples arrive through a single-entry valid/ready holding buffer.
module adc_emulador_spi #(
    parameter int DATA_WIDTH = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int NUM_CH     = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] datos,
    input  logic                         datos_valido,
    output logic                         datos_listo,
    input  logic                         sck_in,
    input  logic                         cs_n_in,
    output logic [NUM_CH-1:0]            miso,
    output logic                         siguiente,
    output logic                         subflujo,
    output logic                         error_trama
);

    localparam int FRAME = LEAD_ZEROS + DATA_WIDTH;
    localparam int CW    = $clog2(FRAME + 1);

    typedef enum logic [1:0] {REPOSO, TRANSMITE, FIN} estado_t;

    estado_t                       state_reg, state_next;
    logic [2:0]                    sck_sync_reg, cs_sync_reg;
    logic                          buf_full_reg;
    logic [NUM_CH*DATA_WIDTH-1:0]  buf_data_reg, last_reg, src;
    logic [CW-1:0]                 cnt_reg;
    logic                          siguiente_reg, subflujo_reg, error_reg;
    logic                          sig_next, sub_next, err_next;
    logic                          load, shift_en, abort;
    logic                          sck_fall, cs_fall, cs_rise;

    // Two synchronizer stages plus one history stage for edge detection.
    // CS resets high and SCK low so no edge is seen right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_reg <= 3'b000;
            cs_sync_reg  <= 3'b111;
        end else begin
            sck_sync_reg <= {sck_sync_reg[1:0], sck_in};
            cs_sync_reg  <= {cs_sync_reg[1:0], cs_n_in};
        end
    end

    assign sck_fall = sck_sync_reg[2] & ~sck_sync_reg[1];
    assign cs_fall  = cs_sync_reg[2] & ~cs_sync_reg[1];
    assign cs_rise  = ~cs_sync_reg[2] & cs_sync_reg[1];

    // A frame uses the queued sample if there is one, otherwise repeats the last.
    assign src = buf_full_reg ? buf_data_reg : last_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= REPOSO;
        else        state_reg <= state_next;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        abort      = 1'b0;
        sig_next   = 1'b0;
        sub_next   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            REPOSO: begin
                // A coincident SCK fall is deliberately ignored here.
                if (cs_fall) begin
                    state_next = TRANSMITE;
                    load       = 1'b1;
                    sub_next   = ~buf_full_reg;
                end
            end
            TRANSMITE: begin
                if (cs_rise) begin
                    state_next = REPOSO;
                    abort      = 1'b1;
                    // Last bit clocked out in the same cycle still counts as complete.
                    if (sck_fall && cnt_reg == CW'(FRAME - 1)) sig_next = 1'b1;
                    else                                       err_next = 1'b1;
                end else if (sck_fall) begin
                    shift_en = 1'b1;
                    if (cnt_reg == CW'(FRAME - 1)) begin
                        state_next = FIN;
                        sig_next   = 1'b1;
                    end
                end
            end
            FIN: begin
                if (cs_rise) state_next = REPOSO;
            end
            default: state_next = REPOSO;
        endcase
    end

    // Holding buffer, last-sample memory and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_reg <= 1'b0;
            buf_data_reg <= '0;
            last_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            if (load && buf_full_reg) begin
                buf_full_reg <= 1'b0;
            end else if (datos_valido && !buf_full_reg) begin
                buf_full_reg <= 1'b1;
                buf_data_reg <= datos;
            end
            if (load) last_reg <= src;
            if (load || abort)  cnt_reg <= '0;
            else if (shift_en)  cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            siguiente_reg <= 1'b0;
            subflujo_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            siguiente_reg <= sig_next;
            subflujo_reg  <= sub_next;
            error_reg     <= err_next;
        end
    end

    assign siguiente   = siguiente_reg;
    assign subflujo    = subflujo_reg;
    assign error_trama = error_reg;
    assign datos_listo = ~buf_full_reg;

    // Per-channel frame shift register: leading zeros sit in the upper bits of
    // the zero-extended sample, so shifting out the MSB yields zeros then data.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_canal
            logic [DATA_WIDTH-1:0] muestra, ordenada;
            logic [FRAME-1:0]      shift_reg;

            assign muestra = src[gi*DATA_WIDTH +: DATA_WIDTH];

            if (MSB_FIRST != 0) begin : g_msb
                assign ordenada = muestra;
            end else begin : g_lsb
                for (genvar bi = 0; bi < DATA_WIDTH; bi++) begin : g_rev
                    assign ordenada[bi] = muestra[DATA_WIDTH-1-bi];
                end
            end

            // Load at frame start, shift one bit per detected SCK fall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        shift_reg <= '0;
                else if (load)     shift_reg <= FRAME'(ordenada);
                else if (shift_en) shift_reg <= shift_reg << 1;
            end

            assign miso[gi] = (state_reg == TRANSMITE) & shift_reg[FRAME-1];
        end
    endgenerate

endmodule

// File: tb/tb_adc_emulador_spi.sv
// Bench for adc_emulador_spi: acts as SPI master, sampling MISO on each SCK
// rise. Expected bits are queued by the stimulus; a monitor pops and compares.
module tb_adc_emulador_spi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] datos = '0;
    logic        datos_valido = 1'b0;
    logic        datos_listo;
    logic        sck_in = 1'b0;
    logic        cs_n_in = 1'b1;
    logic [1:0]  miso;
    logic        siguiente, subflujo, error_trama;

    logic [7:0]  datos8 = '0;
    logic        valido8 = 1'b0;
    logic        listo8;
    logic [0:0]  miso8;
    logic        sig8, sub8, err8;

    int checks = 0;
    int passes = 0;
    int sig_c = 0, sub_c = 0, err_c = 0, sig8_c = 0;

    logic [1:0] q_main[$];
    logic       q8[$];

    always #5 clk = ~clk;

    adc_emulador_spi dut (
        .clk(clk), .rst_n(rst_n), .datos(datos), .datos_valido(datos_valido),
        .datos_listo(datos_listo), .sck_in(sck_in), .cs_n_in(cs_n_in),
        .miso(miso), .siguiente(siguiente), .subflujo(subflujo), .error_trama(error_trama)
    );

    adc_emulador_spi #(.DATA_WIDTH(8), .LEAD_ZEROS(0), .NUM_CH(1), .MSB_FIRST(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .datos(datos8), .datos_valido(valido8),
        .datos_listo(listo8), .sck_in(sck_in), .cs_n_in(cs_n_in),
        .miso(miso8), .siguiente(sig8), .subflujo(sub8), .error_trama(err8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected main-DUT bit pair {ch1,ch0} at bit position i (12-bit, 4 leading zeros, MSB first).
    function automatic logic [1:0] exp_main(input logic [23:0] s, input int i);
        int b;
        if (i < 4 || i >= 16) return 2'b00;
        b = 11 - (i - 4);
        return {s[12+b], s[b]};
    endfunction

    // Expected 8-bit DUT bit at position i (no leading zeros, LSB first).
    function automatic logic exp8(input logic [7:0] s, input int i);
        if (i >= 8) return 1'b0;
        return s[i];
    endfunction

    // Pulse counters.
    always @(negedge clk) begin
        if (siguiente)   sig_c++;
        if (subflujo)    sub_c++;
        if (error_trama) err_c++;
        if (sig8)        sig8_c++;
    end

    // Monitor: master samples MISO on each SCK rise while selected.
    always @(posedge sck_in) begin
        if (!cs_n_in) begin
            if (q_main.size() == 0) begin
                checks++;
                $display("FAIL miso_sin_esperado: got %0h, expected no sample", miso);
            end else begin
                logic [1:0] e;
                e = q_main.pop_front();
                chk("miso_main", {30'd0, miso}, {30'd0, e});
                $display("bit main miso=%b exp=%b", miso, e);
            end
            if (q8.size() > 0) begin
                logic e8;
                e8 = q8.pop_front();
                chk("miso_8bit", {31'd0, miso8}, {31'd0, e8});
                $display("bit 8b   miso=%b exp=%b", miso8, e8);
            end
        end
    end

    task automatic cs_low();
        @(negedge clk) cs_n_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic one_bit();
        sck_in = 1'b1;
        repeat (8) @(negedge clk);
        sck_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input int n, input logic [23:0] s, input bit with8, input logic [7:0] s8);
        for (int i = 0; i < n; i++) begin
            q_main.push_back(exp_main(s, i));
            if (with8) q8.push_back(exp8(s8, i));
        end
        cs_low();
        for (int i = 0; i < n; i++) one_bit();
        cs_high();
        $display("frame: %0d sck falls, sample %h", n, s);
    endtask

    task automatic load_main(input logic [23:0] v);
        @(negedge clk);
        datos = v;
        datos_valido = 1'b1;
        @(negedge clk);
        datos_valido = 1'b0;
        $display("load main %h", v);
    endtask

    int s_sig, s_sub, s_err, s_sig8;

    task automatic snap();
        s_sig = sig_c; s_sub = sub_c; s_err = err_c; s_sig8 = sig8_c;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_miso", {30'd0, miso}, 32'd0);
        chk("reset_listo", {31'd0, datos_listo}, 32'd1);
        chk("reset_pulsos", {29'd0, siguiente, subflujo, error_trama}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // First frame with loaded sample; 8-bit DUT gets 8'h01
        datos8 = 8'h01;
        valido8 = 1'b1;
        load_main({12'hABC, 12'h123});
        valido8 = 1'b0;
        chk("listo_lleno", {31'd0, datos_listo}, 32'd0);
        snap();
        run_frame(16, {12'hABC, 12'h123}, 1'b0, 8'h00);
        chk("f1_siguiente", sig_c - s_sig, 32'd1);
        chk("f1_subflujo", sub_c - s_sub, 32'd0);
        chk("f1_listo", {31'd0, datos_listo}, 32'd1);

        // Second frame, no load: underflow and same bits repeat
        snap();
        run_frame(16, {12'hABC, 12'h123}, 1'b0, 8'h00);
        chk("f2_subflujo", sub_c - s_sub, 32'd1);
        chk("f2_siguiente", sig_c - s_sig, 32'd1);

        // Abort after 7 falls
        snap();
        run_frame(7, {12'hABC, 12'h123}, 1'b0, 8'h00);
        chk("abort_error", err_c - s_err, 32'd1);
        chk("abort_siguiente", sig_c - s_sig, 32'd0);
        chk("abort_miso", {30'd0, miso}, 32'd0);
        snap();
        run_frame(16, {12'hABC, 12'h123}, 1'b0, 8'h00);
        chk("restart_siguiente", sig_c - s_sig, 32'd1);
        chk("restart_error", err_c - s_err, 32'd0);

        // Back-to-back samples 1,2,3 with datos_valido held high
        fork
            begin
                @(negedge clk);
                for (int n = 1; n <= 3; n++) begin
                    int w;
                    w = 0;
                    datos = {12'(n), 12'(n)};
                    datos_valido = 1'b1;
                    while (!datos_listo && w < 5000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 5000) chk("productor_timeout", 32'(w), 32'd0);
                    @(negedge clk);
                    $display("accepted value %0d", n);
                end
                datos_valido = 1'b0;
            end
        join_none
        repeat (5) @(negedge clk);
        chk("cola_listo_bajo", {31'd0, datos_listo}, 32'd0);
        snap();
        run_frame(16, {12'd1, 12'd1}, 1'b0, 8'h00);
        chk("cola_listo_bajo2", {31'd0, datos_listo}, 32'd0);
        run_frame(16, {12'd2, 12'd2}, 1'b0, 8'h00);
        run_frame(16, {12'd3, 12'd3}, 1'b0, 8'h00);
        chk("cola_subflujo", sub_c - s_sub, 32'd0);
        chk("cola_siguiente", sig_c - s_sig, 32'd3);

        // 20 falls: both DUTs pad with zeros and pulse siguiente once
        snap();
        run_frame(20, {12'd3, 12'd3}, 1'b1, 8'h01);
        chk("f20_siguiente", sig_c - s_sig, 32'd1);
        chk("f20_siguiente8", sig8_c - s_sig8, 32'd1);
        chk("f20_subflujo", sub_c - s_sub, 32'd1);

        // Reset at bit 5
        load_main({12'hABC, 12'h123});
        for (int i = 0; i < 5; i++) q_main.push_back(exp_main({12'hABC, 12'h123}, i));
        cs_low();
        for (int i = 0; i < 5; i++) one_bit();
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_miso", {30'd0, miso}, 32'd0);
        chk("rst_listo", {31'd0, datos_listo}, 32'd1);
        chk("rst_miso8", {31'd0, miso8}, 32'd0);
        cs_n_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        snap();
        run_frame(16, 24'h000000, 1'b0, 8'h00);
        chk("post_rst_subflujo", sub_c - s_sub, 32'd1);
        chk("post_rst_siguiente", sig_c - s_sig, 32'd1);

        chk("cola_vacia", 32'(q_main.size() + q8.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
